// File: rtl/ysyx_23060332_mcseq.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060332_mcseq
// Purpose  : Multi-cycle core sequencer. Owns the PC and the
//            fetch/execute/memory/writeback state machine. It talks to
//            instruction and data memory of arbitrary latency through
//            valid/ready handshakes. It also produces the per-instruction
//            commit pulse, the cycle/instret counters and a bus watchdog.
// Ports    : clk/rst             clock, synchronous active-low reset
//            ifu_*               fetch request/response handshake
//            inst_o/pc_o         registered instruction and PC to idu/exu
//            jump_*, is_*, halt_i, mem_*   control and operands from exu
//            lsu_*               data request/response handshake
//            mem_rdata_o         registered load data back to exu
//            reg_*_i / reg_*_o   writeback request in, regfile port out
//            commit_*            one pulse per retired instruction
//            halt_o/err_o/err_code  halt and error status
//            cycle_cnt/instret_cnt  performance counters
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060332_mcseq #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
  parameter int unsigned     TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ifu_req_valid,
  input  logic              ifu_req_ready,
  output logic [XLEN-1:0]   ifu_addr,
  input  logic              ifu_rsp_valid,
  output logic              ifu_rsp_ready,
  input  logic [ILEN-1:0]   ifu_rdata,
  output logic [ILEN-1:0]   inst_o,
  output logic [XLEN-1:0]   pc_o,
  input  logic              jump_en,
  input  logic [XLEN-1:0]   jump_addr,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              halt_i,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN/8-1:0] mem_wmask,
  output logic              lsu_req_valid,
  input  logic              lsu_req_ready,
  output logic              lsu_req_wen,
  output logic [XLEN-1:0]   lsu_addr,
  output logic [XLEN-1:0]   lsu_wdata,
  output logic [XLEN/8-1:0] lsu_wmask,
  input  logic              lsu_rsp_valid,
  output logic              lsu_rsp_ready,
  input  logic [XLEN-1:0]   lsu_rdata,
  output logic [XLEN-1:0]   mem_rdata_o,
  input  logic              reg_wen_i,
  input  logic [4:0]        waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              reg_wen_o,
  output logic [4:0]        waddr_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic              commit_valid,
  output logic [XLEN-1:0]   commit_pc,
  output logic [ILEN-1:0]   commit_inst,
  output logic              halt_o,
  output logic              err_o,
  output logic [1:0]        err_code,
  output logic [63:0]       cycle_cnt,
  output logic [63:0]       instret_cnt
);

  typedef enum logic [2:0] {
    S_IF_REQ   = 3'd0,
    S_IF_WAIT  = 3'd1,
    S_EX       = 3'd2,
    S_MEM_REQ  = 3'd3,
    S_MEM_WAIT = 3'd4,
    S_WB       = 3'd5,
    S_HALT     = 3'd6
  } state_e;

  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [ILEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   pc_o_q, pc_o_d;
  logic [XLEN-1:0]   mem_rdata_q, mem_rdata_d;
  logic [XLEN-1:0]   lsu_addr_q, lsu_addr_d;
  logic [XLEN-1:0]   lsu_wdata_q, lsu_wdata_d;
  logic [XLEN/8-1:0] lsu_wmask_q, lsu_wmask_d;
  logic              lsu_wen_q, lsu_wen_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [63:0]       cycle_q, cycle_d;
  logic [63:0]       instret_q, instret_d;
  logic [31:0]       wd_q, wd_d;
  logic              wd_expired;
  logic              is_bus_state;

  assign wd_expired   = WD_EN && (wd_q == WD_LAST);
  assign is_bus_state = (state_q == S_IF_REQ) || (state_q == S_IF_WAIT) ||
                        (state_q == S_MEM_REQ) || (state_q == S_MEM_WAIT);

  assign ifu_addr    = pc_q;
  assign inst_o      = inst_q;
  assign pc_o        = pc_o_q;
  assign mem_rdata_o = mem_rdata_q;
  assign lsu_addr    = lsu_addr_q;
  assign lsu_wdata   = lsu_wdata_q;
  assign lsu_wmask   = lsu_wmask_q;
  assign lsu_req_wen = lsu_wen_q;
  assign waddr_o     = waddr_i;
  assign wdata_o     = wdata_i;
  assign commit_pc   = pc_o_q;
  assign commit_inst = inst_q;
  assign halt_o      = (state_q == S_HALT);
  assign err_o       = err_q;
  assign err_code    = err_code_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    pc_o_d        = pc_o_q;
    mem_rdata_d   = mem_rdata_q;
    lsu_addr_d    = lsu_addr_q;
    lsu_wdata_d   = lsu_wdata_q;
    lsu_wmask_d   = lsu_wmask_q;
    lsu_wen_d     = lsu_wen_q;
    err_d         = err_q;
    err_code_d    = err_code_q;
    ifu_req_valid = 1'b0;
    ifu_rsp_ready = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_rsp_ready = 1'b0;
    reg_wen_o     = 1'b0;
    commit_valid  = 1'b0;

    // Strobes are gated while reset is held so nothing leaks out before the
    // first released cycle; registers are overwritten by reset anyway.
    if (rst) begin
      unique case (state_q)
        S_IF_REQ: begin
          ifu_req_valid = 1'b1;
          if (ifu_req_ready) begin
            state_d = S_IF_WAIT;
          end else if (wd_expired) begin
            state_d    = S_HALT;
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end
        end
        S_IF_WAIT: begin
          ifu_rsp_ready = 1'b1;
          if (ifu_rsp_valid) begin
            inst_d  = ifu_rdata;
            pc_o_d  = pc_q;
            state_d = S_EX;
          end else if (wd_expired) begin
            state_d    = S_HALT;
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end
        end
        S_EX: begin
          if (halt_i) begin
            // ebreak retires here, the HALT state follows
            commit_valid = 1'b1;
            state_d      = S_HALT;
          end else if (is_load || is_store) begin
            lsu_addr_d  = mem_addr;
            lsu_wdata_d = mem_wdata;
            lsu_wmask_d = mem_wmask;
            lsu_wen_d   = is_store;  // load+store together behaves as a store
            state_d     = S_MEM_REQ;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM_REQ: begin
          lsu_req_valid = 1'b1;
          if (lsu_req_ready) begin
            state_d = S_MEM_WAIT;
          end else if (wd_expired) begin
            state_d    = S_HALT;
            err_d      = 1'b1;
            err_code_d = 2'd2;
          end
        end
        S_MEM_WAIT: begin
          lsu_rsp_ready = 1'b1;
          if (lsu_rsp_valid) begin
            if (!lsu_wen_q) mem_rdata_d = lsu_rdata;
            state_d = S_WB;
          end else if (wd_expired) begin
            state_d    = S_HALT;
            err_d      = 1'b1;
            err_code_d = 2'd2;
          end
        end
        S_WB: begin
          if (jump_en && (jump_addr[1:0] != 2'b00)) begin
            // misaligned target: the instruction does not retire
            state_d    = S_HALT;
            err_d      = 1'b1;
            err_code_d = 2'd3;
          end else begin
            commit_valid = 1'b1;
            reg_wen_o    = reg_wen_i && (waddr_i != 5'd0);
            pc_d         = jump_en ? jump_addr : pc_q + XLEN'(4);
            state_d      = S_IF_REQ;
          end
        end
        default: begin
          state_d = S_HALT;
        end
      endcase
    end

    // The watchdog restarts from zero whenever a bus state is entered.
    wd_d      = (is_bus_state && (state_d == state_q)) ? wd_q + 32'd1 : 32'd0;
    cycle_d   = cycle_q + 64'd1;
    instret_d = instret_q + {63'd0, commit_valid};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IF_REQ;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      pc_o_q      <= '0;
      mem_rdata_q <= '0;
      lsu_addr_q  <= '0;
      lsu_wdata_q <= '0;
      lsu_wmask_q <= '0;
      lsu_wen_q   <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      cycle_q     <= 64'd0;
      instret_q   <= 64'd0;
      wd_q        <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      pc_o_q      <= pc_o_d;
      mem_rdata_q <= mem_rdata_d;
      lsu_addr_q  <= lsu_addr_d;
      lsu_wdata_q <= lsu_wdata_d;
      lsu_wmask_q <= lsu_wmask_d;
      lsu_wen_q   <= lsu_wen_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      cycle_q     <= cycle_d;
      instret_q   <= instret_d;
      wd_q        <= wd_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060332_mcseq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060332_mcseq
// Purpose  : Directed self-checking bench for the multi-cycle sequencer.
//            Expected values are hand-computed from the cycle schedule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060332_mcseq;

  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [31:0] ADDI   = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [63:0] ifu_addr;
  logic [31:0] ifu_rdata, inst_o, commit_inst;
  logic [63:0] pc_o, jump_addr, mem_addr, mem_wdata, lsu_addr, lsu_wdata;
  logic        jump_en, is_load, is_store, halt_i;
  logic [7:0]  mem_wmask, lsu_wmask;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_ready;
  logic [63:0] lsu_rdata, mem_rdata_o, wdata_i, wdata_o, commit_pc;
  logic        reg_wen_i, reg_wen_o, commit_valid, halt_o, err_o;
  logic [4:0]  waddr_i, waddr_o;
  logic [1:0]  err_code;
  logic [63:0] cycle_cnt, instret_cnt;
  logic [63:0] c0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_23060332_mcseq #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
    .inst_o(inst_o), .pc_o(pc_o), .jump_en(jump_en), .jump_addr(jump_addr),
    .is_load(is_load), .is_store(is_store), .halt_i(halt_i),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wen(lsu_req_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
    .mem_rdata_o(mem_rdata_o), .reg_wen_i(reg_wen_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .reg_wen_o(reg_wen_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .halt_o(halt_o), .err_o(err_o), .err_code(err_code),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One non-memory instruction starting in IF_REQ; ends in the following state.
  task automatic run_inst(input logic [63:0] exp_pc, input logic exp_commit, input logic exp_wen);
    check_val("if_addr", ifu_addr, exp_pc);
    check_val("if_req_valid", {63'd0, ifu_req_valid}, 64'd1);
    tick();
    check_val("if_rsp_ready", {63'd0, ifu_rsp_ready}, 64'd1);
    tick();
    check_val("ex_pc_o", pc_o, exp_pc);
    check_val("ex_inst_o", {32'd0, inst_o}, {32'd0, ADDI});
    tick();
    check_val("wb_commit", {63'd0, commit_valid}, {63'd0, exp_commit});
    check_val("wb_reg_wen", {63'd0, reg_wen_o}, {63'd0, exp_wen});
    if (exp_commit) check_val("wb_commit_pc", commit_pc, exp_pc);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b0; ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1; ifu_rdata = ADDI;
    jump_en = 1'b0; jump_addr = '0; is_load = 1'b0; is_store = 1'b0; halt_i = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_wmask = '0; lsu_req_ready = 1'b0;
    lsu_rsp_valid = 1'b0; lsu_rdata = '0; reg_wen_i = 1'b1; waddr_i = 5'd1; wdata_i = 64'h11;
    c0 = '0;

    // ---- reset state ----
    tick(); tick();
    check_val("rst_if_req_valid", {63'd0, ifu_req_valid}, 64'd0);
    check_val("rst_commit", {63'd0, commit_valid}, 64'd0);
    check_val("rst_if_addr", ifu_addr, RST_PC);
    check_val("rst_inst_o", {32'd0, inst_o}, 64'd0);
    check_val("rst_pc_o", pc_o, 64'd0);
    check_val("rst_halt", {63'd0, halt_o}, 64'd0);
    check_val("rst_err_code", {62'd0, err_code}, 64'd0);
    check_val("rst_cycle", cycle_cnt, 64'd0);
    check_val("rst_instret", instret_cnt, 64'd0);
    rst = 1'b1; #1;
    check_val("rel_if_req_valid", {63'd0, ifu_req_valid}, 64'd1);

    // ---- stream of addi, zero-wait memory ----
    for (int i = 0; i < 3; i++) run_inst(RST_PC + 64'(4 * i), 1'b1, 1'b1);
    check_val("stream_instret", instret_cnt, 64'd3);
    check_val("stream_cycle", cycle_cnt, 64'd12);

    // ---- aligned jump ----
    jump_en = 1'b1; jump_addr = 64'h8000_0100;
    run_inst(64'h8000_000c, 1'b1, 1'b1);
    jump_en = 1'b0;

    // ---- write to x0 still commits ----
    waddr_i = 5'd0;
    run_inst(64'h8000_0100, 1'b1, 1'b0);

    // ---- load with delayed handshakes ----
    c0 = cycle_cnt;
    check_val("ld_if_addr", ifu_addr, 64'h8000_0104);
    is_load = 1'b1; mem_addr = 64'h8000_1008; mem_wmask = 8'hff; mem_wdata = 64'h55;
    waddr_i = 5'd7; reg_wen_i = 1'b1;
    tick(); tick(); tick();
    mem_addr = 64'hbad; mem_wmask = 8'h00; is_load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_val("ld_req_valid", {63'd0, lsu_req_valid}, 64'd1);
      check_val("ld_addr_hold", lsu_addr, 64'h8000_1008);
      check_val("ld_wmask_hold", {56'd0, lsu_wmask}, 64'hff);
      tick();
    end
    lsu_req_ready = 1'b1;
    check_val("ld_req_valid_acc", {63'd0, lsu_req_valid}, 64'd1);
    check_val("ld_wen", {63'd0, lsu_req_wen}, 64'd0);
    tick();
    lsu_req_ready = 1'b0;
    check_val("ld_rsp_ready", {63'd0, lsu_rsp_ready}, 64'd1);
    check_val("ld_req_dropped", {63'd0, lsu_req_valid}, 64'd0);
    tick(); tick();
    lsu_rsp_valid = 1'b1; lsu_rdata = 64'hcafe_f00d_1234_5678;
    tick();
    lsu_rsp_valid = 1'b0;
    check_val("ld_rdata", mem_rdata_o, 64'hcafe_f00d_1234_5678);
    check_val("ld_reg_wen", {63'd0, reg_wen_o}, 64'd1);
    check_val("ld_waddr", {59'd0, waddr_o}, 64'd7);
    check_val("ld_commit", {63'd0, commit_valid}, 64'd1);
    check_val("ld_cycles", cycle_cnt - c0, 64'd10);
    tick();
    check_val("ld_total", cycle_cnt - c0, 64'd11);

    // ---- misaligned jump ----
    jump_en = 1'b1; jump_addr = 64'h8000_0102; waddr_i = 5'd3;
    run_inst(64'h8000_0108, 1'b0, 1'b0);
    jump_en = 1'b0;
    check_val("mis_halt", {63'd0, halt_o}, 64'd1);
    check_val("mis_err", {63'd0, err_o}, 64'd1);
    check_val("mis_err_code", {62'd0, err_code}, 64'd3);
    check_val("mis_if_req", {63'd0, ifu_req_valid}, 64'd0);
    check_val("mis_instret", instret_cnt, 64'd6);
    tick();
    check_val("halt_absorb", {63'd0, halt_o}, 64'd1);

    // ---- ebreak ----
    rst = 1'b0; tick(); rst = 1'b1; #1;
    halt_i = 1'b1;
    check_val("eb_if_addr", ifu_addr, RST_PC);
    tick(); tick();
    check_val("eb_commit", {63'd0, commit_valid}, 64'd1);
    check_val("eb_commit_pc", commit_pc, RST_PC);
    tick();
    halt_i = 1'b0;
    check_val("eb_halt", {63'd0, halt_o}, 64'd1);
    check_val("eb_err", {63'd0, err_o}, 64'd0);
    check_val("eb_instret", instret_cnt, 64'd1);

    // ---- reset during MEM_WAIT ----
    rst = 1'b0; tick(); rst = 1'b1; #1;
    is_store = 1'b1; mem_addr = 64'h2000; mem_wdata = 64'hdead; mem_wmask = 8'h0f;
    lsu_req_ready = 1'b1;
    tick(); tick(); tick();
    check_val("st_req_valid", {63'd0, lsu_req_valid}, 64'd1);
    check_val("st_wen", {63'd0, lsu_req_wen}, 64'd1);
    check_val("st_wdata", lsu_wdata, 64'hdead);
    tick();
    check_val("st_rsp_ready", {63'd0, lsu_rsp_ready}, 64'd1);
    rst = 1'b0; lsu_rsp_valid = 1'b1; #1;
    check_val("mrst_commit", {63'd0, commit_valid}, 64'd0);
    check_val("mrst_reg_wen", {63'd0, reg_wen_o}, 64'd0);
    tick();
    check_val("mrst_if_addr", ifu_addr, RST_PC);
    check_val("mrst_cycle", cycle_cnt, 64'd0);
    check_val("mrst_instret", instret_cnt, 64'd0);
    check_val("mrst_lsu_wen", {63'd0, lsu_req_wen}, 64'd0);
    rst = 1'b1; lsu_rsp_valid = 1'b0; is_store = 1'b0; lsu_req_ready = 1'b0; #1;
    check_val("mrst_if_req_valid", {63'd0, ifu_req_valid}, 64'd1);

    // ---- fetch watchdog ----
    ifu_rsp_valid = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) tick();
    check_val("wd_before", {63'd0, halt_o}, 64'd0);
    check_val("wd_rsp_ready", {63'd0, ifu_rsp_ready}, 64'd1);
    tick();
    check_val("wd_halt", {63'd0, halt_o}, 64'd1);
    check_val("wd_err", {63'd0, err_o}, 64'd1);
    check_val("wd_err_code", {62'd0, err_code}, 64'd1);
    check_val("wd_cycle", cycle_cnt, 64'd9);
    tick();
    check_val("wd_cycle_run", cycle_cnt, 64'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_23060332_mcseq.md
# ysyx_23060332_mcseq

Multi-cycle core sequencer: successor to the single-cycle core top, replacing its combinational fetch/memory path with valid/ready handshakes to instruction and data memory of arbitrary latency. Owns the PC, the fetch/execute/memory/writeback state machine, the per-instruction commit pulse, performance counters and a bus watchdog. Sits between the decode/execute datapath (idu/exu, regfile) and the IFU/LSU bus ports.

## Interface
- XLEN, 64, data and address width
- ILEN, 32, instruction width
- RESET_PC, 64'h8000_0000, first fetch address
- TIMEOUT, 255, maximum cycles spent in any one bus state; 0 disables the watchdog
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- ifu_req_valid  out  1  fetch request valid
- ifu_req_ready  in  1  fetch request accepted
- ifu_addr  out  XLEN  fetch address (current PC)
- ifu_rsp_valid  in  1  fetch data valid
- ifu_rsp_ready  out  1  sequencer accepts fetch data
- ifu_rdata  in  ILEN  fetched instruction
- inst_o / pc_o  out  ILEN / XLEN  registered instruction and its PC to idu/exu
- jump_en / jump_addr  in  1 / XLEN  from exu: redirect
- is_load / is_store / halt_i  in  1 each  from exu: instruction class; halt_i = ebreak
- mem_addr / mem_wdata / mem_wmask  in  XLEN / XLEN / XLEN/8  from exu
- lsu_req_valid / lsu_req_ready  out / in  1  data request handshake
- lsu_req_wen  out  1  1 = store
- lsu_addr / lsu_wdata / lsu_wmask  out  XLEN / XLEN / XLEN/8  latched request
- lsu_rsp_valid / lsu_rsp_ready  in / out  1  data response handshake
- lsu_rdata  in  XLEN  load data
- mem_rdata_o  out  XLEN  registered load data back to exu
- reg_wen_i / waddr_i / wdata_i  in  1 / 5 / XLEN  writeback request from exu
- reg_wen_o / waddr_o / wdata_o  out  1 / 5 / XLEN  regfile write port
- commit_valid / commit_pc / commit_inst  out  1 / XLEN / ILEN  one pulse per retired instruction
- halt_o / err_o / err_code  out  1 / 1 / 2  halted; error; 0 none, 1 fetch timeout, 2 mem timeout, 3 misaligned jump
- cycle_cnt / instret_cnt  out  64 each  performance counters

## Operation
- States: IF_REQ, IF_WAIT, EX, MEM_REQ, MEM_WAIT, WB, HALT.
- IF_REQ: ifu_req_valid=1, ifu_addr=PC; on ifu_req_ready -> IF_WAIT.
- IF_WAIT: ifu_rsp_ready=1; on ifu_rsp_valid latch inst_o=ifu_rdata, pc_o=PC -> EX.
- EX (1 cycle, exu combinational on inst_o): halt_i -> HALT (commits, err_o=0); else is_load|is_store -> latch lsu_addr/wdata/wmask/wen -> MEM_REQ; else -> WB. is_load and is_store both 1: treat as store.
- MEM_REQ: lsu_req_valid=1; on lsu_req_ready -> MEM_WAIT. MEM_WAIT: lsu_rsp_ready=1; on lsu_rsp_valid latch mem_rdata_o=lsu_rdata (loads only) -> WB.
- WB (1 cycle): reg_wen_o = reg_wen_i & (waddr_i!=0), waddr_o/wdata_o pass through; commit_valid=1; PC <= jump_en ? jump_addr : PC+4; -> IF_REQ. jump_en with jump_addr[1:0]!=0: no PC update, no reg write, commit_valid=0, -> HALT, err_code=3.
- Request outputs held stable while valid & !ready. Response valids outside their wait state ignored.
- Watchdog: counter cleared on entering each bus state, increments per cycle in it; reaching TIMEOUT -> HALT, err_o=1, err_code=1 (IF_*) or 2 (MEM_*).
- HALT: absorbing until reset; all valid/ready/wen outputs 0; halt_o=1.
- cycle_cnt +1 every non-reset cycle incl. HALT; instret_cnt +1 per commit_valid (including halt commit). Both wrap modulo 2^64.

## Timing
- Reset (rst=0 at edge): state IF_REQ, PC=RESET_PC, all handshake/wen/commit outputs 0, inst_o=0, pc_o=0, mem_rdata_o=0, lsu_* latches 0, halt_o=0, err_o=0, err_code=0, counters 0. ifu_req_valid rises combinationally in the first cycle after release.
- Reset mid-transaction: outstanding bus responses dropped; no commit, no reg write.
- Zero-wait memory: non-memory instruction 4 cycles, load/store 6 cycles, commit to next ifu_req_valid 1 cycle.
- Outputs from state only (Moore); no combinational path from ready/valid inputs to valid outputs.
- halt commit: commit_valid pulses in the EX cycle, halt_o=1 from the next cycle.

## Test plan
- Reset release, ifu ready/valid always 1, stream of addi: ifu_addr 0x80000000, 0x80000004…; commit_valid every 4 cycles; instret_cnt=N after N commits.
- Load with lsu_req_ready delayed 3 cycles, lsu_rsp_valid 2 further: lsu_addr/wmask stable throughout, mem_rdata_o=lsu_rdata, reg_wen_o pulse at WB, total 11 cycles.
- jump_en=1, jump_addr=0x80000100 -> next ifu_addr 0x80000100; jump_addr=0x80000102 -> HALT, err_code=3, no reg write, no commit.
- TIMEOUT=8, ifu_rsp_valid never asserted: HALT after 8 IF_WAIT cycles, err_o=1, err_code=1; cycle_cnt keeps counting.
- Write to x0 (reg_wen_i=1, waddr_i=0): reg_wen_o stays 0, commit_valid still 1; ebreak: one commit, then halt_o=1, err_o=0.
- rst=0 asserted in MEM_WAIT with lsu_rsp_valid=1 same cycle: no commit; next cycle state IF_REQ, ifu_addr=RESET_PC, counters 0.
